// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, EX redirect,
// decode stall and the IF/ID presentation signals.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_exc;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_exc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_stall
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_exc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_stall
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC, in-order fetch buffer, stale-response drop.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect halts fetch and presents one exception NOP.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int unsigned      PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    logic [31:0]           pc_q;
    logic [31:0]           buf_pc    [FIFO_DEPTH];
    logic [31:0]           buf_instr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] filled_q;
    logic [CNT_W-1:0]      wr_ptr_q, fill_ptr_q, rd_ptr_q, drop_cnt_q;
    logic [CNT_W-1:0]      count, unfilled;
    logic [PTR_W-1:0]      wr_idx, fill_idx, rd_idx;
    logic                  halt_q, exc_pend_q;
    logic [31:0]           exc_pc_q;
    logic [31:0]           redir_target;
    logic                  redir_misalign;
    logic                  head_valid, alloc, pop_entry, fill;

`ifdef FETCH_MISALIGN_CHK_EN
    assign redir_target   = bus.redirect_pc;
    assign redir_misalign = |bus.redirect_pc[1:0];
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
    assign redir_target   = {bus.redirect_pc[31:2], 2'b00};
    assign redir_misalign = 1'b0;
`endif

    // Extended pointers: occupancy and unfilled counts are plain differences.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign unfilled = wr_ptr_q - fill_ptr_q;
    assign wr_idx   = wr_ptr_q[PTR_W-1:0];
    assign fill_idx = fill_ptr_q[PTR_W-1:0];
    assign rd_idx   = rd_ptr_q[PTR_W-1:0];

    assign head_valid = (count != '0) && filled_q[rd_idx];

    always_comb begin
        bus.imem_req_valid = !rst && !bus.redirect_valid && !halt_q &&
                             ((count + drop_cnt_q) < DEPTH_C);
        bus.imem_req_addr  = pc_q;
        bus.if_valid       = !rst && (exc_pend_q || head_valid);
        bus.if_exc         = !rst && exc_pend_q;
        bus.if_pc          = exc_pend_q ? exc_pc_q : buf_pc[rd_idx];
        bus.if_instr       = exc_pend_q ? NOP      : buf_instr[rd_idx];
    end

    assign alloc     = bus.imem_req_valid && bus.imem_req_ready;
    assign pop_entry = head_valid && !exc_pend_q && !bus.id_stall;
    assign fill      = bus.imem_rsp_valid && (drop_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
            filled_q   <= '0;
        end else if (bus.redirect_valid) begin
            // Every in-flight response now belongs to a flushed entry, including
            // any arriving this cycle, which is discarded right here.
            pc_q       <= redir_target;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= drop_cnt_q + unfilled - CNT_W'(bus.imem_rsp_valid);
        end else begin
            if (alloc) begin
                buf_pc[wr_idx]   <= pc_q;
                filled_q[wr_idx] <= 1'b0;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
                pc_q             <= pc_q + 32'd4;
            end
            if (bus.imem_rsp_valid && !fill) begin
                drop_cnt_q <= drop_cnt_q - 1'b1;
            end
            if (fill) begin
                buf_instr[fill_idx] <= bus.imem_rsp_data;
                filled_q[fill_idx]  <= 1'b1;
                fill_ptr_q          <= fill_ptr_q + 1'b1;
            end
            if (pop_entry) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q     <= 1'b0;
            exc_pend_q <= 1'b0;
            exc_pc_q   <= '0;
        end else if (bus.redirect_valid) begin
            halt_q     <= redir_misalign;
            exc_pend_q <= redir_misalign;
            exc_pc_q   <= bus.redirect_pc;
        end else if (exc_pend_q && !bus.id_stall) begin
            exc_pend_q <= 1'b0;
        end
    end
`else
    logic unused_misalign;
    assign unused_misalign = redir_misalign;
    assign halt_q     = 1'b0;
    assign exc_pend_q = 1'b0;
    assign exc_pc_q   = '0;
`endif
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage in-order RV32 core. It owns the PC, issues word requests to instruction memory through a valid/ready handshake, and tracks responses in an in-order buffer. It presents `{pc, instr}` to the IF/ID register feeding decode and the control unit. Stalls come from the hazard unit; redirects come from branch/jump resolution in EX.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC of first fetch after reset.
- `FIFO_DEPTH`, 4, fetch buffer entries. Power of two, ≥2. This is also the maximum number of requests in flight.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 32: word address of the request. Always equals `pc_q`.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: response valid. Responses arrive one per accepted request, in order, at least 1 cycle after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: EX redirect (taken branch, JAL, JALR).
- `redirect_pc` in 32: redirect target.
- `id_stall` in 1: decode cannot accept this cycle.
- `if_valid` out 1: `if_pc`, `if_instr` and `if_exc` are valid.
- `if_pc` out 32: PC of the presented instruction.
- `if_instr` out 32: presented instruction.
- `if_exc` out 1: instruction-address-misaligned marker (see Configuration).

## Operation
- **State:**
  - `pc_q`
  - circular buffer of `FIFO_DEPTH` entries `{pc, instr, filled}`
  - write pointer (alloc), fill pointer, read pointer
  - `count` (allocated entries)
  - `drop_cnt` (stale responses to discard, 0..FIFO_DEPTH)
- **Request:**
  - `imem_req_valid = !redirect_valid && !halt_q && (count + drop_cnt) < FIFO_DEPTH`.
  - On accept: allocate an entry with `pc = pc_q`, `filled = 0`; then `pc_q <= pc_q + 4` (mod 2^32, wraps silently).
- **Response:**
  - If `drop_cnt > 0`: discard the data and decrement `drop_cnt`.
  - Otherwise: write `imem_rsp_data` into the entry at the fill pointer, set `filled`, advance the fill pointer.
- **Output:**
  - `if_valid` = head entry allocated and filled.
  - `if_pc` and `if_instr` come from the head entry.
  - Pop when `if_valid && !id_stall`.
  - While `id_stall` is high, outputs hold stable.
- **Simultaneous events:** alloc, fill and pop may all occur in one cycle. `count` updates by `+alloc - pop`.
- **Redirect** (highest priority):
  - All entries are flushed; `count`, all pointers and `if_valid` go to 0 next cycle.
  - `pc_q <= redirect_pc`.
  - `drop_cnt <= drop_cnt + unfilled_entries - imem_rsp_valid`. The response arriving this cycle is always stale.
  - No request is issued in the redirect cycle.
  - Redirect overrides a concurrent pop or `id_stall`; a same-cycle pop is not counted as consumed by decode.
- **Full:** with `count + drop_cnt == FIFO_DEPTH`, `imem_req_valid` is 0. The PC holds.
- **Reset:**
  - `pc_q = RESET_PC`.
  - `count`, pointers, `drop_cnt` and `halt_q` = 0.
  - `imem_req_valid`, `if_valid` and `if_exc` = 0 during reset.
  - `imem_req_addr = RESET_PC` after reset.
  - Reset mid-operation discards everything. Instruction memory shares `rst`, so no responses from before reset arrive after it.

## Timing
- Request to presentation: a response in cycle t gives `if_valid` in t+1. The buffer is registered and there is no bypass.
- After `rst` falls at edge 0: request for RESET_PC issues in cycle 0. With a 1-cycle memory, the response comes in cycle 1 and `if_valid` in cycle 2.
- Steady state with a 1-cycle memory, no stall and `FIFO_DEPTH ≥ 3`: one instruction per cycle.
- Redirect in cycle t: first request to the target in t+1; earliest `if_valid` for it in t+3.
- No combinational path from `id_stall` to `imem_req_valid`.
- No combinational path from `imem_rsp_*` to `if_*`.

## Configuration
- **`FETCH_MISALIGN_CHK_EN` defined:**
  - A redirect with `redirect_pc[1:0] != 0` issues no request and sets `halt_q`.
  - Next cycle, one pseudo-entry is presented: `if_valid = 1`, `if_pc = redirect_pc`, `if_instr = 32'h0000_0013` (NOP), `if_exc = 1`. It obeys `id_stall`.
  - After it is popped, fetch stays halted until the next redirect or reset.
- **Undefined:**
  - `redirect_pc[1:0]` is forced to 2'b00.
  - `if_exc` is tied to 0.
  - `halt_q` is constant 0.

## Test plan
- Reset release, memory always ready with 1-cycle response returning `addr ^ 32'hA5A5_0000` → requests 0x0, 0x4, 0x8… on consecutive cycles; `if_valid` from cycle 2; `if_pc` = 0x0, 0x4, 0x8 with matching data; one instruction per cycle.
- `id_stall` high for 5 cycles mid-stream → `if_pc`/`if_instr` hold; requests stop once 4 are allocated; after release, PCs continue without gap or duplicate.
- 3-cycle memory latency with 3 outstanding requests, then redirect to 0x100 → the 3 stale responses are dropped; next `if_valid` shows `if_pc` = 0x100 with its data; no instruction from before the redirect appears.
- Redirect in the same cycle as `imem_rsp_valid` and pop → that response is discarded; `if_valid` = 0 next cycle; next presented PC = target.
- Redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC, then 0x0000_0000 (wrap).
- With `FETCH_MISALIGN_CHK_EN`, redirect to 0x102 → one output with `if_exc` = 1, `if_pc` = 0x102, `if_instr` = 0x13; no further requests until redirect to 0x200. Without the macro → fetch resumes at 0x100.
